// File: rtl/sysbus_pkg.sv
//==============================================================================
// Module  : sysbus_pkg
// Brief   : Shared types and constants for the sysbus RAM responder.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package sysbus_pkg;

    localparam int   c_WORD_W         = 8;
    localparam logic c_STROBE_ACTIVE  = 1'b0;   // NCE / NOE / NWE
    localparam logic c_ADDRCP_ACTIVE  = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DRIVE = 2'd2,
        WR_HOLD  = 2'd3
    } ram_state_t;

endpackage

`default_nettype wire

// File: rtl/sysbus_ram_array.sv
//==============================================================================
// Module  : sysbus_ram_array
// Brief   : Single-port storage, synchronous read and write, 2**ADDR_W words.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module sysbus_ram_array #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rd_en,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [2**ADDR_W];
    logic [WORD_W-1:0] r_rdata;

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_rd_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/sysbus_ram.sv
//==============================================================================
// Module  : sysbus_ram
// Brief   : Strobe-decoding RAM responder on the shared tri-state sysbus.
//           Define SYSBUS_RAM_CHECK_EN to build the sticky bus_err checker.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module sysbus_ram
    import sysbus_pkg::*;
#(
    parameter int WORD_W   = c_WORD_W,
    parameter int ADDR_W   = WORD_W,
    parameter int READ_LAT = 1
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic              RAM_NCE,
    input  logic              RAM_NOE,
    input  logic              RAM_NWE,
    input  logic              RAM_ADDRCP,
    inout  wire  [WORD_W-1:0] sysbus,
    output logic              rd_drive,
    output logic              bus_err
);

    localparam int c_CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    ram_state_t          r_state, w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0]   r_addr_q;
    logic [WORD_W-1:0]   r_wdata_q;
    logic [WORD_W-1:0]   w_rdata_q;
    logic                w_sel, w_cap, w_rd, w_wr, w_conflict;
    logic                w_rd_en, w_wr_en, w_wdata_ld;

    assign w_sel      = (RAM_NCE == c_STROBE_ACTIVE);
    assign w_cap      = w_sel & (RAM_ADDRCP == c_ADDRCP_ACTIVE);
    assign w_rd       = w_sel & (RAM_NOE == c_STROBE_ACTIVE);
    assign w_wr       = w_sel & (RAM_NWE == c_STROBE_ACTIVE);
    assign w_conflict = w_rd & w_wr;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr_q  <= '0;
            r_wdata_q <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_cap) begin
                r_addr_q <= sysbus[ADDR_W-1:0];
            end
            if (w_wdata_ld) begin
                r_wdata_q <= sysbus;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rd_en     = 1'b0;
        w_wr_en     = 1'b0;
        w_wdata_ld  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_cap && w_rd && !w_wr) begin
                    w_state_nxt = RD_WAIT;
                    w_cnt_nxt   = c_CNT_W'(READ_LAT - 1);
                    w_rd_en     = 1'b1;
                end else if (!w_cap && w_wr && !w_rd) begin
                    w_state_nxt = WR_HOLD;
                    w_wdata_ld  = 1'b1;
                end
            end
            RD_WAIT: begin
                if (!w_rd || w_conflict) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == '0) begin
                    w_state_nxt = RD_DRIVE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RD_DRIVE: begin
                if (!w_rd || w_conflict) begin
                    w_state_nxt = IDLE;
                end
            end
            WR_HOLD: begin
                // Commit uses the value captured on the last low-NWE cycle.
                if (w_conflict) begin
                    w_state_nxt = IDLE;
                end else if (w_wr) begin
                    w_wdata_ld = 1'b1;
                end else begin
                    w_wr_en     = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    sysbus_ram_array #(
        .WORD_W (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clock),
        .rst_n   (n_reset),
        .i_rd_en (w_rd_en),
        .i_wr_en (w_wr_en),
        .i_addr  (r_addr_q),
        .i_wdata (r_wdata_q),
        .o_rdata (w_rdata_q)
    );

    // Gate is combinational on the live strobes so the bus is released
    // in the very cycle the CPU deasserts NOE/NCE or raises a conflict.
    assign rd_drive = (r_state == RD_DRIVE) & w_rd & !w_wr;
    assign sysbus   = rd_drive ? w_rdata_q : {WORD_W{1'bz}};

`ifdef SYSBUS_RAM_CHECK_EN
    logic r_bus_err;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_bus_err <= 1'b0;
        end else if (w_conflict || (w_cap && (w_rd || w_wr))) begin
            r_bus_err <= 1'b1;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign bus_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sysbus_ram.sv
//==============================================================================
// Module  : tb_sysbus_ram
// Brief   : Directed self-checking bench for sysbus_ram (8-bit and 4-bit address).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sysbus_ram;
    import sysbus_pkg::*;

    logic       clock = 1'b0;
    logic       n_reset;
    logic       nce, noe, nwe, addrcp;
    logic       tb_oe;
    logic [7:0] tb_dat;
    wire  [7:0] bus, bus4;
    logic       rd_drive, bus_err, rd_drive4, bus_err4;
    logic [7:0] d8, d4;
    logic       exp_err;
    int         checks = 0;
    int         errors = 0;

    assign bus  = tb_oe ? tb_dat : 8'hzz;
    assign bus4 = tb_oe ? tb_dat : 8'hzz;

    always #5 clock = ~clock;

    sysbus_ram dut (
        .clock(clock), .n_reset(n_reset), .RAM_NCE(nce), .RAM_NOE(noe),
        .RAM_NWE(nwe), .RAM_ADDRCP(addrcp), .sysbus(bus),
        .rd_drive(rd_drive), .bus_err(bus_err)
    );

    sysbus_ram #(.ADDR_W(4)) dut4 (
        .clock(clock), .n_reset(n_reset), .RAM_NCE(nce), .RAM_NOE(noe),
        .RAM_NWE(nwe), .RAM_ADDRCP(addrcp), .sysbus(bus4),
        .rd_drive(rd_drive4), .bus_err(bus_err4)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic addr_cap(input logic [7:0] a);
        nce = 1'b0; addrcp = 1'b1; tb_oe = 1'b1; tb_dat = a;
        step();
        addrcp = 1'b0; tb_oe = 1'b0;
    endtask

    task automatic wr(input logic [7:0] v0, input logic [7:0] v1);
        nwe = 1'b0; tb_oe = 1'b1; tb_dat = v0;
        step();
        tb_dat = v1;
        step();
        nwe = 1'b1; tb_oe = 1'b0;
        step();
    endtask

    // Leaves NOE low with the bus driven; rel() ends the access.
    task automatic rd(input string tag, output logic [7:0] o8, output logic [7:0] o4);
        noe = 1'b0;
        step();
        chk({tag, "_early"}, {7'd0, rd_drive}, 8'd0);
        step();
        chk({tag, "_drive"}, {7'd0, rd_drive}, 8'd1);
        o8 = bus;
        o4 = bus4;
    endtask

    task automatic rel(input string tag);
        noe = 1'b1;
        #1;
        chk({tag, "_release"}, {7'd0, rd_drive}, 8'd0);
        step();
        chk({tag, "_idle"}, {6'd0, dut.r_state}, {6'd0, IDLE});
    endtask

    initial begin
`ifdef SYSBUS_RAM_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        n_reset = 1'b0; nce = 1'b1; noe = 1'b1; nwe = 1'b1; addrcp = 1'b0;
        tb_oe = 1'b0; tb_dat = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        n_reset = 1'b1;
        step();

        // Reset release
        chk("rst_rd_drive", {7'd0, rd_drive}, 8'd0);
        chk("rst_bus_err", {7'd0, bus_err}, 8'd0);
        chk("rst_state", {6'd0, dut.r_state}, {6'd0, IDLE});

        // Write then read back with READ_LAT+1 latency; NOE held one more cycle
        addr_cap(8'h12);
        wr(8'hA5, 8'hA5);
        addr_cap(8'h12);
        rd("t2", d8, d4);
        chk("t2_data", d8, 8'hA5);
        step();
        chk("t2_hold", bus, 8'hA5);
        rel("t3");

        // Last low-NWE value committed when NCE rises
        addr_cap(8'h40);
        nwe = 1'b0; tb_oe = 1'b1; tb_dat = 8'h33;
        step();
        tb_dat = 8'h44;
        step();
        nce = 1'b1;
        step();
        nwe = 1'b1; tb_oe = 1'b0; nce = 1'b0;
        addr_cap(8'h40);
        rd("t4a", d8, d4);
        chk("t4a_data", d8, 8'h44);
        rel("t4a");

        // Reset pulse during WR_HOLD discards the pending write
        addr_cap(8'h40);
        nwe = 1'b0; tb_oe = 1'b1; tb_dat = 8'h99;
        step();
        step();
        n_reset = 1'b0;
        #1;
        chk("t4b_async_idle", {6'd0, dut.r_state}, {6'd0, IDLE});
        nwe = 1'b1; tb_oe = 1'b0;
        step();
        n_reset = 1'b1;
        step();
        addr_cap(8'h40);
        rd("t4b", d8, d4);
        chk("t4b_data", d8, 8'h44);
        rel("t4b");
        chk("t4b_bus_err", {7'd0, bus_err}, 8'd0);

        // NOE and NWE low together from IDLE
        addr_cap(8'h50);
        wr(8'h11, 8'h11);
        addr_cap(8'h50);
        noe = 1'b0; nwe = 1'b0;
        step();
        chk("t5_no_drive1", {7'd0, rd_drive}, 8'd0);
        chk("t5_err", {7'd0, bus_err}, {7'd0, exp_err});
        step();
        chk("t5_no_drive2", {7'd0, rd_drive}, 8'd0);
        noe = 1'b1; nwe = 1'b1;
        step();
        chk("t5_err_sticky", {7'd0, bus_err}, {7'd0, exp_err});
        rd("t5a", d8, d4);
        chk("t5a_data", d8, 8'h11);
        rel("t5a");

        // Conflict during WR_HOLD aborts without commit
        nwe = 1'b0; tb_oe = 1'b1; tb_dat = 8'h22;
        step();
        noe = 1'b0;
        step();
        chk("t5b_abort_idle", {6'd0, dut.r_state}, {6'd0, IDLE});
        noe = 1'b1; nwe = 1'b1; tb_oe = 1'b0;
        step();
        addr_cap(8'h50);
        rd("t5b", d8, d4);
        chk("t5b_data", d8, 8'h11);
        rel("t5b");
        chk("t5b_err_sticky", {7'd0, bus_err}, {7'd0, exp_err});

        // ADDR_W=4: upper address bits ignored
        addr_cap(8'hF3);
        wr(8'h5C, 8'h5C);
        addr_cap(8'h03);
        rd("t6", d8, d4);
        chk("t6_drive4", {7'd0, rd_drive4}, 8'd1);
        chk("t6_data4", d4, 8'h5C);
        rel("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
